// File: rtl/img_matrix_rank_3_3.sv
// 3x3 rank filter (median / min / max) with a 3-stage pipeline and ce stall.
// Optional IMG_RANK_CENTER_BYPASS_EN: mode 11 forwards matrix_p22 instead of the median.
module img_matrix_rank_3_3 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] matrix_p11,
  input  logic [DATA_W-1:0] matrix_p12,
  input  logic [DATA_W-1:0] matrix_p13,
  input  logic [DATA_W-1:0] matrix_p21,
  input  logic [DATA_W-1:0] matrix_p22,
  input  logic [DATA_W-1:0] matrix_p23,
  input  logic [DATA_W-1:0] matrix_p31,
  input  logic [DATA_W-1:0] matrix_p32,
  input  logic [DATA_W-1:0] matrix_p33,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  typedef logic [DATA_W-1:0] pix_t;

  typedef enum logic [1:0] {
    MODE_MEDIAN = 2'b00,
    MODE_MIN    = 2'b01,
    MODE_MAX    = 2'b10,
    MODE_CENTER = 2'b11
  } mode_e;

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  pix_t win [9];
  assign win[0] = matrix_p11;
  assign win[1] = matrix_p12;
  assign win[2] = matrix_p13;
  assign win[3] = matrix_p21;
  assign win[4] = matrix_p22;
  assign win[5] = matrix_p23;
  assign win[6] = matrix_p31;
  assign win[7] = matrix_p32;
  assign win[8] = matrix_p33;

  // Stage 1: per-row sort
  pix_t  row_max [3];
  pix_t  row_mid [3];
  pix_t  row_min [3];

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      row_max[r] = max2(max2(win[3*r], win[3*r+1]), win[3*r+2]);
      row_min[r] = min2(min2(win[3*r], win[3*r+1]), win[3*r+2]);
      row_mid[r] = med3(win[3*r], win[3*r+1], win[3*r+2]);
    end
  end

  pix_t  s1_max [3];
  pix_t  s1_mid [3];
  pix_t  s1_min [3];
  mode_e s1_mode;
  logic  s1_valid;

  // Stage 2: candidates for median plus global extremes
  pix_t  s2_lo_max;
  pix_t  s2_med_mid;
  pix_t  s2_hi_min;
  pix_t  s2_gmax;
  pix_t  s2_gmin;
  mode_e s2_mode;
  logic  s2_valid;

`ifdef IMG_RANK_CENTER_BYPASS_EN
  pix_t  s1_ctr;
  pix_t  s2_ctr;
`endif

  pix_t  s3_med;
  pix_t  s3_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (ce) begin
      s1_valid <= in_valid;
      s1_mode  <= mode_e'(mode);
      for (int unsigned r = 0; r < 3; r++) begin
        s1_max[r] <= row_max[r];
        s1_mid[r] <= row_mid[r];
        s1_min[r] <= row_min[r];
      end
`ifdef IMG_RANK_CENTER_BYPASS_EN
      s1_ctr   <= matrix_p22;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (ce) begin
      s2_valid   <= s1_valid;
      s2_mode    <= s1_mode;
      s2_lo_max  <= min2(min2(s1_max[0], s1_max[1]), s1_max[2]);
      s2_med_mid <= med3(s1_mid[0], s1_mid[1], s1_mid[2]);
      s2_hi_min  <= max2(max2(s1_min[0], s1_min[1]), s1_min[2]);
      s2_gmax    <= max2(max2(s1_max[0], s1_max[1]), s1_max[2]);
      s2_gmin    <= min2(min2(s1_min[0], s1_min[1]), s1_min[2]);
`ifdef IMG_RANK_CENTER_BYPASS_EN
      s2_ctr     <= s1_ctr;
`endif
    end
  end

  // Stage 3: final median and mode select
  always_comb begin
    s3_med = med3(s2_lo_max, s2_med_mid, s2_hi_min);
    s3_sel = s3_med;
    case (s2_mode)
      MODE_MIN:    s3_sel = s2_gmin;
      MODE_MAX:    s3_sel = s2_gmax;
`ifdef IMG_RANK_CENTER_BYPASS_EN
      MODE_CENTER: s3_sel = s2_ctr;
`else
      MODE_CENTER: s3_sel = s3_med;
`endif
      default:     s3_sel = s3_med;
    endcase
  end

  // out_data only moves on a valid slot so idle cycles keep the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ce) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= s3_sel;
      end
    end
  end

endmodule

// File: tb/tb_img_matrix_rank_3_3.sv
// Bench for img_matrix_rank_3_3: 8-bit and 12-bit instances against a sort-based reference.
module tb_img_matrix_rank_3_3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] win [9];

  logic        v8;
  logic [7:0]  o8;
  logic        v12;
  logic [11:0] o12;

  int checks = 0;
  int failures = 0;

  // reference pipeline state per instance: [0]=8-bit, [1]=12-bit
  logic        pv [2][2];
  logic [15:0] pd [2][2];
  logic        ev [2];
  logic [15:0] ed [2];

  always #5 clk = ~clk;

  img_matrix_rank_3_3 #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .mode(mode),
    .matrix_p11(win[0][7:0]), .matrix_p12(win[1][7:0]), .matrix_p13(win[2][7:0]),
    .matrix_p21(win[3][7:0]), .matrix_p22(win[4][7:0]), .matrix_p23(win[5][7:0]),
    .matrix_p31(win[6][7:0]), .matrix_p32(win[7][7:0]), .matrix_p33(win[8][7:0]),
    .out_valid(v8), .out_data(o8)
  );

  img_matrix_rank_3_3 #(.DATA_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .mode(mode),
    .matrix_p11(win[0][11:0]), .matrix_p12(win[1][11:0]), .matrix_p13(win[2][11:0]),
    .matrix_p21(win[3][11:0]), .matrix_p22(win[4][11:0]), .matrix_p23(win[5][11:0]),
    .matrix_p31(win[6][11:0]), .matrix_p32(win[7][11:0]), .matrix_p33(win[8][11:0]),
    .out_valid(v12), .out_data(o12)
  );

  function automatic logic [15:0] ref_rank(input logic [15:0] w [9], input int bits,
                                           input logic [1:0] m);
    logic [15:0] s [9];
    logic [15:0] mask;
    logic [15:0] t;
    mask = 16'((32'd1 << bits) - 1);
    for (int i = 0; i < 9; i++) s[i] = w[i] & mask;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    case (m)
      2'b01:   return s[0];
      2'b10:   return s[8];
`ifdef IMG_RANK_CENTER_BYPASS_EN
      2'b11:   return w[4] & mask;
`endif
      default: return s[4];
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // one rising edge: advance reference, then compare both instances
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pv[d][0] = 1'b0; pv[d][1] = 1'b0; ev[d] = 1'b0; ed[d] = '0;
      end else if (ce) begin
        ev[d] = pv[d][1];
        if (pv[d][1]) ed[d] = pd[d][1];
        pv[d][1] = pv[d][0];
        pd[d][1] = pd[d][0];
        pv[d][0] = in_valid;
        pd[d][0] = ref_rank(win, (d == 0) ? 8 : 12, mode);
      end
    end
    #1;
    check("valid8",  {15'd0, v8},  {15'd0, ev[0]});
    check("data8",   {8'd0, o8},   ed[0]);
    check("valid12", {15'd0, v12}, {15'd0, ev[1]});
    check("data12",  {4'd0, o12},  ed[1]);
  endtask

  task automatic set_win(input logic [15:0] a, b, c, d, e, f, g, h, i);
    win[0] = a; win[1] = b; win[2] = c;
    win[3] = d; win[4] = e; win[5] = f;
    win[6] = g; win[7] = h; win[8] = i;
  endtask

  task automatic rand_win();
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 3))
        0:       win[i] = 16'h0000;
        1:       win[i] = 16'hFFFF;
        default: win[i] = 16'($urandom);
      endcase
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pv[d][0] = 1'b0; pv[d][1] = 1'b0; pd[d][0] = '0; pd[d][1] = '0;
      ev[d] = 1'b0; ed[d] = '0;
    end
    set_win(1, 2, 3, 4, 5, 6, 7, 8, 9);
    in_valid = 1'b1;

    // reset state
    tick();
    tick();
    check("rst_valid", {15'd0, v8}, 16'd0);
    check("rst_data", {8'd0, o8}, 16'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();

    // single median window, 3-edge latency
    set_win(9, 1, 5, 3, 7, 2, 8, 4, 6);
    mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("lat_early", {15'd0, v8}, 16'd0);
    tick();
    check("med_valid", {15'd0, v8}, 16'd1);
    check("med_data", {8'd0, o8}, 16'd5);
    tick();
    check("idle_hold", {8'd0, o8}, 16'd5);

    // mode changes on consecutive windows
    in_valid = 1'b1;
    mode = 2'b01; tick();
    mode = 2'b10; tick();
    mode = 2'b00; tick();
    check("mode_min", {8'd0, o8}, 16'd1);
    in_valid = 1'b0;
    tick();
    check("mode_max", {8'd0, o8}, 16'd9);
    tick();
    check("mode_med", {8'd0, o8}, 16'd5);
    tick();

    // extremes
    in_valid = 1'b1; mode = 2'b00;
    set_win(255, 255, 255, 255, 255, 255, 255, 255, 255); tick();
    set_win(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_win(0, 255, 0, 255, 0, 255, 0, 255, 0); tick();
    check("all255", {8'd0, o8}, 16'd255);
    in_valid = 1'b0;
    tick();
    check("all0", {8'd0, o8}, 16'd0);
    tick();
    check("checker", {8'd0, o8}, 16'd0);
    tick();

    // ce stall mid-flight
    set_win(9, 1, 5, 3, 7, 2, 8, 4, 6);
    in_valid = 1'b1; mode = 2'b10;
    tick();
    ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rand_win();
      mode = 2'($urandom);
      tick();
      check("stall_valid", {15'd0, v8}, 16'd0);
    end
    ce = 1'b1; in_valid = 1'b0;
    tick();
    tick();
    check("stall_out_v", {15'd0, v8}, 16'd1);
    check("stall_out_d", {8'd0, o8}, 16'd9);
    tick();

    // reset with two windows in flight
    in_valid = 1'b1; mode = 2'b00;
    set_win(10, 20, 30, 40, 50, 60, 70, 80, 90); tick();
    set_win(90, 80, 70, 60, 50, 40, 30, 20, 11); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    check("rst_fl_v", {15'd0, v8}, 16'd0);
    check("rst_fl_d", {8'd0, o8}, 16'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("no_stale", {15'd0, v8}, 16'd0);
    end

    // center bypass and 12-bit extremes
    in_valid = 1'b1; mode = 2'b11;
    set_win(9, 1, 5, 3, 77, 2, 8, 4, 6); tick();
    mode = 2'b00;
    set_win(4095, 2048, 0, 1, 4094, 100, 3000, 4000, 7); tick();
    set_win(4095, 0, 4095, 0, 4095, 0, 4095, 0, 4095); tick();
`ifdef IMG_RANK_CENTER_BYPASS_EN
    check("center", {8'd0, o8}, 16'd77);
`else
    check("center", {8'd0, o8}, 16'd5);
`endif
    in_valid = 1'b0;
    tick();
    check("w12_mix", {4'd0, o12}, 16'd2048);
    tick();
    check("w12_ext", {4'd0, o12}, 16'd4095);
    tick();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rand_win();
      in_valid = 1'($urandom);
      mode = 2'($urandom);
      ce = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0; ce = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/img_matrix_rank_3_3.md
IMG_MATRIX_RANK_3_3 -- requirements
Module: img_matrix_rank_3_3

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, pixel bit width (legal 1..16).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 The block SHALL have port ce, input, 1, pipeline advance enable; low freezes all registers.
REQ-005 The block SHALL have port in_valid, input, 1, window present on matrix ports this cycle.
REQ-006 The block SHALL have port mode, input, 2, operation for this window: 00 median, 01 min, 10 max, 11 per REQ-021/REQ-022.
REQ-007 The block SHALL have ports matrix_p11..matrix_p33, input, DATA_W each, 3x3 window, row-major, unsigned.
REQ-008 The block SHALL have port out_valid, input-aligned valid, output, 1.
REQ-009 The block SHALL have port out_data, output, DATA_W, selected rank result.

Function
REQ-010 Pipeline SHALL be 3 stages; window accepted at edge N (ce=1, in_valid=1) SHALL appear on out_data with out_valid=1 after edge N+2 (i.e. 3 ce-enabled edges), with no combinational input-to-output path.
REQ-011 Stage 1 SHALL sort each row into max/mid/min using unsigned compares; equal values in any order give identical results.
REQ-012 Stage 2 SHALL compute min of row-maxes, median of row-mids, max of row-mins, global max (max of row-maxes), global min (min of row-mins).
REQ-013 Stage 3 SHALL compute median of the three stage-2 candidates and select out_data by the mode carried with the window.
REQ-014 mode SHALL be sampled with the window and travel down the pipeline; changing mode mid-stream SHALL affect only windows accepted after the change.
REQ-015 A valid bit SHALL travel with each stage; cycles with in_valid=0 SHALL produce out_valid=0 in their output slot, with out_data holding its previous value.
REQ-016 Back-to-back windows SHALL be accepted every ce-enabled cycle (throughput 1/cycle).
REQ-017 While ce=0, all data, mode and valid registers SHALL hold; out_valid and out_data SHALL stay constant; inputs are ignored.
REQ-018 Results SHALL be exact for all values 0..2^DATA_W-1, including all-equal windows and extremes.

Reset
REQ-019 With rst=1 at a rising edge, all stage valid bits, out_valid and out_data SHALL be 0 at the next cycle, regardless of ce.
REQ-020 Windows in flight at reset SHALL be discarded; first out_valid after reset SHALL be 3 ce-enabled edges after the first accepted window.

Configuration
REQ-021 With macro IMG_RANK_CENTER_BYPASS_EN defined, mode 11 SHALL output matrix_p22 of that window, delayed by the same 3-stage latency.
REQ-022 Without IMG_RANK_CENTER_BYPASS_EN, mode 11 SHALL behave exactly as mode 00 (median) and no center-pixel delay registers SHALL exist.

Verification
REQ-023 DATA_W=8, ce=1, mode=00, window 9,1,5/3,7,2/8,4,6 -> out_valid=1, out_data=5 exactly 3 edges later.
REQ-024 Same window, consecutive cycles mode=01, 10, 00 -> outputs 1, 9, 5 on consecutive cycles, each 3 edges after its input.
REQ-025 All-255 window then all-0 window, mode 00 -> 255 then 0; window 0,255,0/255,0,255/0,255,0 -> median 0.
REQ-026 Accept window, drop ce for 4 cycles after 1 edge, restore -> out_valid rises after 2 more ce-enabled edges, value correct, outputs frozen while ce=0.
REQ-027 Two windows in flight, assert rst one cycle -> out_valid=0, out_data=0 next cycle; no stale result appears afterwards.
REQ-028 mode=11 with center pixel 77, median 5 -> 77 with IMG_RANK_CENTER_BYPASS_EN, 5 without; DATA_W=12 window with 4095/0 mix -> exact median.
